fft_frame_loader: RTL

- Input-side stage directly upstream of the 16-point parallel radix-2 FFT core.
- Collects a stream of complex samples, one per cycle, into 16-sample frames.
- Optionally places samples in bit-reversed order, then presents each complete frame as 16 parallel complex words with a valid/ready handshake.
- Double-buffered (ping-pong) so the next frame fills while the current one is presented; applies back-pressure upstream when both banks are occupied.

---
 rtl/fft_frame_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader in front of the 16-point FFT core: gathers one complex
// sample per cycle into a 16-slot bank (optionally bit-reversed) and presents full banks in parallel.
module fft_frame_loader #(
  parameter int DATA_W      = 16,
  parameter int N           = 16,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_real,
  input  logic [DATA_W-1:0]     in_imag,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*DATA_W-1:0]   out_real_flat,
  output logic [N*DATA_W-1:0]   out_imag_flat,
  output logic [15:0]           frame_count,
  output logic                  err_misalign
);

  logic signed [DATA_W-1:0] re_q [2][N];
  logic signed [DATA_W-1:0] re_d [2][N];
  logic signed [DATA_W-1:0] im_q [2][N];
  logic signed [DATA_W-1:0] im_d [2][N];
  logic [1:0]  full_q, full_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        err_q, err_d;
  logic        accept, rel;
  logic [3:0]  slot;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  assign in_ready     = !full_q[wr_bank_q];
  assign out_valid    = full_q[rd_bank_q];
  assign frame_count  = frame_count_q;
  assign err_misalign = err_q;
  assign accept       = in_valid && in_ready;
  assign rel          = out_valid && out_ready;
  assign slot         = BIT_REVERSE ? bitrev4(wr_idx_q) : wr_idx_q;

  // Release and close always target different banks: the write bank is never full
  // while accepting, and the read bank is always full while releasing.
  always_comb begin
    re_d          = re_q;
    im_d          = im_q;
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    frame_count_d = frame_count_q;
    err_d         = err_q;
    if (rel) begin
      for (int j = 0; j < N; j++) begin
        re_d[rd_bank_q][j] = '0;
        im_d[rd_bank_q][j] = '0;
      end
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_count_d     = frame_count_q + 16'd1;
    end
    if (accept) begin
      re_d[wr_bank_q][slot] = in_real;
      im_d[wr_bank_q][slot] = in_imag;
      wr_idx_d              = wr_idx_q + 4'd1;
      if (wr_idx_q == 4'hF || in_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = 4'd0;
      end
      // in_last must coincide exactly with the 16th sample
      if ((wr_idx_q == 4'hF) != in_last) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < N; j++) begin
          re_q[b][j] <= '0;
          im_q[b][j] <= '0;
        end
      end
      full_q        <= 2'b00;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= 4'd0;
      frame_count_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      re_q          <= re_d;
      im_q          <= im_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign out_real_flat[j*DATA_W +: DATA_W] = re_q[rd_bank_q][j];
    assign out_imag_flat[j*DATA_W +: DATA_W] = im_q[rd_bank_q][j];
  end

endmodule
